// File: rtl/md_issue_ctrl_if.sv
// Bundle between the EX-stage HI/LO issue controller, the pipeline and the multdiv unit.
// The slave view belongs to the controller. The master view is the environment:
// the pipeline request side together with the multdiv unit return path.
interface md_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic [2:0]        cmd;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              ex_flush;
    logic              stall;
    logic              mf_valid;
    logic [DATA_W-1:0] mf_data;
    logic              md_start;
    logic [1:0]        md_op;
    logic              md_we;
    logic              md_hilo;
    logic [DATA_W-1:0] md_d1;
    logic [DATA_W-1:0] md_d2;
    logic              md_busy;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic              err;

    modport slave (
        input  req, cmd, rs_val, rt_val, ex_flush, md_busy, md_hi, md_lo,
        output stall, mf_valid, mf_data, md_start, md_op, md_we, md_hilo,
        output md_d1, md_d2, err
    );

    modport master (
        output req, cmd, rs_val, rt_val, ex_flush, md_busy, md_hi, md_lo,
        input  stall, mf_valid, mf_data, md_start, md_op, md_we, md_hilo,
        input  md_d1, md_d2, err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// EX-stage initiator for the multdiv HI/LO unit. It accepts MULT/DIV/MF/MT requests,
// hides the one-cycle gap between the start pulse and the unit raising busy, and
// stalls the pipeline until the unit can take or answer the next request.
module md_issue_ctrl #(
    parameter bit         DIVZ_SUPPRESS = 1'b1,
    parameter logic [4:0] TIMEOUT       = 5'd31,
    parameter int         DATA_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    md_issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] timer;

    logic is_md;
    logic is_mf;
    logic is_mt;
    logic div_zero;
    logic ready;
    logic accept;
    logic issue;
    logic timeout;
    logic force_idle;

    // Request decode, handshake and the combinational MF read-back path.
    always_comb begin
        is_md      = ~bus.cmd[2];
        is_mf      = bus.cmd[2] & ~bus.cmd[1];
        is_mt      = bus.cmd[2] & bus.cmd[1];
        // A divide by zero is swallowed so HI/LO keep their previous contents.
        div_zero   = DIVZ_SUPPRESS && is_md && bus.cmd[1] && (bus.rt_val == '0);
        ready      = ((state == S_IDLE) || (state == S_WAIT)) && !bus.md_busy;
        accept     = bus.req && !bus.ex_flush && ready;
        issue      = accept && ((is_md && !div_zero) || is_mt);
        timeout    = (state != S_IDLE) && (timer == TIMEOUT);
        // A unit that answers on the timeout cycle still wins over the watchdog.
        force_idle = timeout && !ready;
        bus.stall    = bus.req && !bus.ex_flush && !ready;
        bus.mf_valid = accept && is_mf;
        bus.mf_data  = '0;
        if (bus.mf_valid) begin
            bus.mf_data = bus.cmd[0] ? bus.md_lo : bus.md_hi;
        end
    end

    // Next-state selection; WAIT reuses the IDLE transitions once the unit is free.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (force_idle) begin
                    state_nxt = S_IDLE;
                end else if (bus.md_start) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (ready) begin
                    state_nxt = issue ? S_ISSUE : S_IDLE;
                end else if (force_idle) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, watchdog timer (runs only while waiting on the unit) and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bus.err <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt == S_WAIT) ? timer + 5'd1 : 5'd0;
            if (force_idle) begin
                bus.err <= 1'b1;
            end
        end
    end

    // Registered unit interface: one-cycle pulses plus operands held until the next issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.md_start <= 1'b0;
            bus.md_we    <= 1'b0;
            bus.md_op    <= 2'b00;
            bus.md_hilo  <= 1'b0;
            bus.md_d1    <= '0;
            bus.md_d2    <= '0;
        end else begin
            bus.md_start <= issue && is_md;
            bus.md_we    <= issue && is_mt;
            if (issue) begin
                bus.md_d1 <= bus.rs_val;
            end
            if (issue && is_md) begin
                bus.md_d2 <= bus.rt_val;
                bus.md_op <= bus.cmd[1:0];
            end
            if (issue && is_mt) begin
                bus.md_hilo <= ~bus.cmd[0];
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a behavioural multdiv unit, an architectural HI/LO
// reference and a scoreboard of expected start / write / read-back events.
module tb_md_issue_ctrl;

    logic clk;
    logic reset;
    logic force_busy;
    int   cyc;
    int   nchecks;
    int   nerr;

    md_issue_ctrl_if #(.DATA_W(32)) m ();

    md_issue_ctrl #(
        .DIVZ_SUPPRESS(1'b1),
        .TIMEOUT      (5'd31),
        .DATA_W       (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // {hi, lo} result of a multiply/divide as the architecture defines it.
    function automatic logic [63:0] md_calc(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa   = a;
        sb   = b;
        case (op)
            2'd0: md_calc = {32'd0, a} * {32'd0, b};
            2'd1: md_calc = sa64 * sb64;
            2'd2: begin
                if (b == 32'd0) md_calc = 64'd0;
                else            md_calc = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin
                    md_calc = 64'd0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    md_calc = {32'd0, 32'h8000_0000};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    md_calc = {r, q};
                end
            end
        endcase
    endfunction

    // Behavioural multdiv unit: busy rises the cycle after start, 5 (mult) or 10 (div) cycles.
    int          u_cnt;
    logic [31:0] u_hi;
    logic [31:0] u_lo;
    logic [63:0] u_pend;
    always @(posedge clk) begin
        if (reset) begin
            u_cnt <= 0;
            u_hi  <= 32'd0;
            u_lo  <= 32'd0;
        end else begin
            if (m.md_start) begin
                u_pend <= md_calc(m.md_op, m.md_d1, m.md_d2);
                u_cnt  <= m.md_op[1] ? 10 : 5;
            end else if (u_cnt > 0) begin
                u_cnt <= u_cnt - 1;
                if (u_cnt == 1) begin
                    u_hi <= u_pend[63:32];
                    u_lo <= u_pend[31:0];
                end
            end
            if (m.md_we) begin
                if (m.md_hilo) u_hi <= m.md_d1;
                else           u_lo <= m.md_d1;
            end
        end
    end
    assign m.md_busy = (u_cnt != 0) || force_busy;
    assign m.md_hi   = u_hi;
    assign m.md_lo   = u_lo;

    // Scoreboard: kind 0 start {op,d1,d2}, kind 1 HI/LO write {hilo,d1}, kind 2 read-back {data}.
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ev_t;
    ev_t exq[$];
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        return e;
    endfunction

    // Architectural effect of an accepted instruction.
    task automatic ref_accept(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
        case (c)
            3'd0, 3'd1: begin
                exq.push_back(mk(0, {30'd0, c[1:0]}, rs, rt));
                {ref_hi, ref_lo} = md_calc(c[1:0], rs, rt);
            end
            3'd2, 3'd3: begin
                if (rt != 32'd0) begin
                    exq.push_back(mk(0, {30'd0, c[1:0]}, rs, rt));
                    {ref_hi, ref_lo} = md_calc(c[1:0], rs, rt);
                end
            end
            3'd4: exq.push_back(mk(2, ref_hi, 32'd0, 32'd0));
            3'd5: exq.push_back(mk(2, ref_lo, 32'd0, 32'd0));
            3'd6: begin
                exq.push_back(mk(1, 32'd1, rs, 32'd0));
                ref_hi = rs;
            end
            default: begin
                exq.push_back(mk(1, 32'd0, rs, 32'd0));
                ref_lo = rs;
            end
        endcase
    endtask

    task automatic pop_check(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
        ev_t e;
        if (exq.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL unexpected_event kind=%0d actual=%h/%h/%h required=none (cycle %0d)",
                     k, a, b, c, cyc);
        end else begin
            e = exq.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            if (e.kind == k) begin
                case (k)
                    0: begin
                        chk("start_op", a, e.a);
                        chk("start_d1", b, e.b);
                        chk("start_d2", c, e.c);
                    end
                    1: begin
                        chk("we_hilo", a, e.a);
                        chk("we_d1", b, e.b);
                    end
                    default: chk("mf_data", a, e.a);
                endcase
            end
        end
    endtask

    // Monitor: samples between edges and consumes one expected event per DUT output event.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (m.mf_valid) pop_check(2, m.mf_data, 32'd0, 32'd0);
                if (m.md_start) pop_check(0, {30'd0, m.md_op}, m.md_d1, m.md_d2);
                if (m.md_we)    pop_check(1, {31'd0, m.md_hilo}, m.md_d1, 32'd0);
                if (!m.mf_valid) chk("mf_data_idle", m.mf_data, 32'd0);
            end
        end
    end

    // Present a request until it is accepted; returns accept cycle and stall count.
    task automatic issue(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt,
                         output int acc, output int nst);
        bit done;
        done = 1'b0;
        acc  = -1;
        nst  = 0;
        m.req = 1'b1; m.cmd = c; m.rs_val = rs; m.rt_val = rt; m.ex_flush = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (!m.stall) begin
                done = 1'b1;
                acc  = cyc;
                ref_accept(c, rs, rt);
            end else begin
                nst++;
            end
            @(posedge clk);
            #1;
        end
        m.req = 1'b0;
        nchecks++;
        if (!done) begin
            nerr++;
            $display("FAIL accept_timeout cmd=%0d actual=stalled required=accepted", c);
        end
    endtask

    task automatic flush_req(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
        m.req = 1'b1; m.cmd = c; m.rs_val = rs; m.rt_val = rt; m.ex_flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, m.stall}, 32'd0);
        chk("flush_mf_valid", {31'd0, m.mf_valid}, 32'd0);
        @(posedge clk);
        #1;
        m.req = 1'b0;
        m.ex_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},    {31'd0, m.stall},    32'd0);
        chk({tag, "_mf_valid"}, {31'd0, m.mf_valid}, 32'd0);
        chk({tag, "_mf_data"},  m.mf_data,           32'd0);
        chk({tag, "_md_start"}, {31'd0, m.md_start}, 32'd0);
        chk({tag, "_md_we"},    {31'd0, m.md_we},    32'd0);
        chk({tag, "_md_op"},    {30'd0, m.md_op},    32'd0);
        chk({tag, "_md_hilo"},  {31'd0, m.md_hilo},  32'd0);
        chk({tag, "_md_d1"},    m.md_d1,             32'd0);
        chk({tag, "_md_d2"},    m.md_d2,             32'd0);
        chk({tag, "_err"},      {31'd0, m.err},      32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       pick = 32'd0;
            1:       pick = 32'hFFFF_FFFF;
            2:       pick = 32'h8000_0000;
            3:       pick = 32'($urandom_range(0, 15));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        int          a0;
        int          a1;
        int          a2;
        int          n0;
        int          waited;
        logic [2:0]  c;
        logic [31:0] rs;
        logic [31:0] rt;

        nchecks = 0; nerr = 0; cyc = 0;
        reset = 1'b1; force_busy = 1'b0;
        m.req = 1'b0; m.cmd = 3'd0; m.rs_val = 32'd0; m.rt_val = 32'd0; m.ex_flush = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0;
        idle(3);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // MULT -1 * 2, then back-to-back MFHI/MFLO
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, a0, n0);
        issue(3'd4, 32'd0, 32'd0, a1, n0);
        issue(3'd5, 32'd0, 32'd0, a2, n0);
        chk("mult_mfhi_latency", 32'(a1 - a0), 32'd7);
        chk("mult_mflo_latency", 32'(a2 - a0), 32'd8);

        // MULTU same operands
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, a0, n0);
        issue(3'd4, 32'd0, 32'd0, a1, n0);
        issue(3'd5, 32'd0, 32'd0, a2, n0);

        // DIV -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, a0, n0);
        issue(3'd5, 32'd0, 32'd0, a1, n0);
        issue(3'd4, 32'd0, 32'd0, a2, n0);
        chk("div_mflo_latency", 32'(a1 - a0), 32'd12);

        // MTHI while the unit is busy dividing
        issue(3'd3, 32'd100, 32'd7, a0, n0);
        issue(3'd6, 32'h0000_1234, 32'd0, a1, n0);
        issue(3'd4, 32'd0, 32'd0, a2, n0);
        chk("mthi_accept_latency", 32'(a1 - a0), 32'd12);
        chk("mfhi_after_mt_latency", 32'(a2 - a1), 32'd2);

        // Divide by zero is swallowed: no start, no stall, LO keeps the MTLO value
        issue(3'd7, 32'h0000_ABCD, 32'd0, a0, n0);
        idle(2);
        issue(3'd3, 32'd5, 32'd0, a0, n0);
        chk("divz_stalls", 32'(n0), 32'd0);
        issue(3'd2, 32'd9, 32'd0, a0, n0);
        chk("divuz_stalls", 32'(n0), 32'd0);
        issue(3'd5, 32'd0, 32'd0, a1, n0);
        chk("mflo_after_divz_stalls", 32'(n0), 32'd0);

        // Flushed requests never issue, even while the unit is busy
        flush_req(3'd1, 32'd3, 32'd3);
        flush_req(3'd4, 32'd0, 32'd0);
        idle(3);
        issue(3'd1, 32'd7, 32'd9, a0, n0);
        flush_req(3'd5, 32'd0, 32'd0);
        idle(2);
        flush_req(3'd6, 32'd55, 32'd0);
        issue(3'd5, 32'd0, 32'd0, a1, n0);
        chk("mflo_after_flush_latency", 32'(a1 - a0), 32'd7);

        // Reset while waiting on the unit
        issue(3'd1, 32'd3, 32'd4, a0, n0);
        idle(3);
        reset = 1'b1;
        ref_hi = 32'd0; ref_lo = 32'd0;
        idle(1);
        @(negedge clk);
        check_all_zero("reset_in_wait");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Unit stuck busy: watchdog returns to IDLE and raises a sticky err
        issue(3'd0, 32'd5, 32'd6, a0, n0);
        force_busy = 1'b1;
        idle(20);
        @(negedge clk);
        chk("err_before_timeout", {31'd0, m.err}, 32'd0);
        waited = 0;
        while (!m.err && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("err_after_timeout", {31'd0, m.err}, 32'd1);
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        idle(12);
        @(negedge clk);
        chk("err_sticky", {31'd0, m.err}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ref_hi = 32'd0; ref_lo = 32'd0;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_reset", {31'd0, m.err}, 32'd0);
        @(posedge clk);
        #1;

        // Randomised instruction stream against the architectural HI/LO reference
        for (int i = 0; i < 200; i++) begin
            c  = 3'($urandom_range(0, 7));
            rs = pick();
            rt = pick();
            if ($urandom_range(0, 7) == 0) flush_req(c, rs, rt);
            else                           issue(c, rs, rt, a0, n0);
            idle($urandom_range(0, 2));
        end
        issue(3'd4, 32'd0, 32'd0, a0, n0);
        issue(3'd5, 32'd0, 32'd0, a0, n0);

        idle(5);
        chk("scoreboard_empty", 32'(exq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule
